ex_mem_stage_register: RTL
==========================

Name: ex_mem_stage_register

Overview:
- Pipeline register between the EX stage (ALU result and Zero flag) and the MEM stage.
- Captures the ALU outputs and the control bundle, and resolves conditional branches (BEQ/BNE) from Zero.
- Squashes wrong-path instructions after a taken branch using a kill counter.
- Supports pipeline stall and flush from the hazard unit, and gives the forwarding unit a registered EX/MEM write-back value.

Parameters:
- DATA_WIDTH, 32, width of ALU result, store data and PC values
- REG_ADDR_WIDTH, 5, register-file address width
- KILL_SLOTS, 1, number of younger instructions squashed after a taken branch (1..3)
- LINK_REG, 31, destination register forced for JAL

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- Stall  in  1  hold all state this cycle
- Flush  in  1  replace captured instruction with a bubble
- Valid_i  in  1  EX-stage instruction is real (not a bubble)
- ALUResult_i  in  DATA_WIDTH  ALU result
- Zero_i  in  1  ALU zero flag
- WriteData_i  in  DATA_WIDTH  rt value for stores
- WriteRegister_i  in  REG_ADDR_WIDTH  destination register
- PCPlus4_i  in  DATA_WIDTH  PC+4 of the EX instruction
- BranchTarget_i  in  DATA_WIDTH  computed branch target
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, BranchEQ_i, BranchNE_i, Jal_i  in  1 each  control bits
- Valid_o  out  1  MEM-stage instruction is real
- ALUResult_o, WriteData_o  out  DATA_WIDTH  registered data
- WriteRegister_o  out  REG_ADDR_WIDTH  registered destination (LINK_REG when Jal)
- ForwardValue_o  out  DATA_WIDTH  registered value: PCPlus4 if Jal, else ALUResult
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1  registered control, gated by Valid
- BranchTaken_o  out  1  registered branch decision
- BranchTarget_o  out  DATA_WIDTH  registered target
- KillActive_o  out  1  kill counter non-zero

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; WriteRegister_o = 0; kill counter = 0.
  - Reset asserted mid-operation discards everything, including pending kills.
- Update priority at each rising edge: reset > Flush > Stall > load.
- Load:
  - eff_valid = Valid_i & (killcnt==0).
  - Capture all data fields.
  - Control outputs = control_i & eff_valid.
  - Valid_o = eff_valid.
  - Latency is 1 cycle.
- Branch decision: BranchTaken_o <= eff_valid & ((BranchEQ_i & Zero_i) | (BranchNE_i & ~Zero_i)). BranchEQ_i and BranchNE_i both set: either condition taken (OR).
- Kill counter:
  - On a load with a taken decision, killcnt <= KILL_SLOTS.
  - Otherwise, on a load with killcnt>0, killcnt decrements by 1.
  - The decrement happens whether or not Valid_i=1 (bubbles consume slots).
  - A taken branch cannot be captured while killcnt>0, because eff_valid=0 then.
- Jal: WriteRegister_o <= LINK_REG, ForwardValue_o <= PCPlus4_i, RegWrite_o forced to 1 when eff_valid.
- Stall: every register holds, including killcnt and BranchTaken_o.
- Flush:
  - Valid_o, all control outputs and BranchTaken_o <= 0.
  - Data fields <= 0.
  - killcnt <= 0.
  - Flush with Stall simultaneous: Flush wins.
- Arithmetic: no arithmetic besides the counter. The counter is 2 bits and never wraps: it decrements only when non-zero.
- KillActive_o = (killcnt != 0), a registered-state decode.

Decomposition:
- Shared package mips_pipeline_pkg:
  - width constants (DATA_WIDTH, REG_ADDR_WIDTH)
  - LINK_REG
  - packed typedef ex_mem_ctrl_t {RegWrite, MemRead, MemWrite, MemtoReg, BranchEQ, BranchNE, Jal}
- Sub-module branch_kill_counter (load, decrement, hold, clear; outputs killcnt != 0). It is natural to separate and reusable for the ID/EX stage.

Test Plan:
1. Reset 0 while loading ALUResult_i=32'h1234_5678 -> all outputs 0 immediately, no clock needed. Release reset, one clock -> ALUResult_o=32'h1234_5678, Valid_o=1.
2. BEQ: Valid_i=1, BranchEQ_i=1, Zero_i=1, BranchTarget_i=32'h0040_0020 -> next cycle BranchTaken_o=1, BranchTarget_o=32'h0040_0020, KillActive_o=1. Following load with Valid_i=1, RegWrite_i=1 -> Valid_o=0, RegWrite_o=0, KillActive_o=0.
3. BNE with Zero_i=1 -> BranchTaken_o=0, no kill. BNE with Zero_i=0 -> BranchTaken_o=1.
4. JAL: PCPlus4_i=32'h0040_0008, WriteRegister_i=5 -> WriteRegister_o=31, ForwardValue_o=32'h0040_0008, RegWrite_o=1.
5. Stall held 3 cycles while inputs change -> outputs unchanged, kill count unchanged. Then Stall=1 with Flush=1 -> Valid_o=0, all controls 0, killcnt=0.
6. KILL_SLOTS=2, taken branch, then one bubble and one valid input -> both squashed (Valid_o=0 twice). Third input passes with Valid_o=1.

Source files
------------

// File: rtl/mips_pipeline_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pipeline_pkg : shared widths and control bundle for stages  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mips_pipeline_pkg;

  localparam int c_data_width     = 32;
  localparam int c_reg_addr_width = 5;
  localparam int c_link_reg       = 31;

  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic MemtoReg;
    logic BranchEQ;
    logic BranchNE;
    logic Jal;
  } ex_mem_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/branch_kill_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_kill_counter : counts younger slots to squash after a     |
// | taken branch. Rev 1.0                                            |
// +------------------------------------------------------------------+
module branch_kill_counter #(
  parameter int KILL_SLOTS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic advance,
  output logic active
);

  localparam logic [1:0] c_slots = 2'(KILL_SLOTS);

  logic [1:0] r_count;

  // Saturates at zero: decrement only while slots remain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
    end else if (clear) begin
      r_count <= 2'd0;
    end else if (load) begin
      r_count <= c_slots;
    end else if (advance && (r_count != 2'd0)) begin
      r_count <= r_count - 2'd1;
    end
  end

  assign active = (r_count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage_register.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_mem_stage_register : EX/MEM pipeline register with branch     |
// | resolution and wrong-path squash. Rev 1.0                        |
// +------------------------------------------------------------------+
module ex_mem_stage_register
  import mips_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = c_data_width,
  parameter int REG_ADDR_WIDTH = c_reg_addr_width,
  parameter int KILL_SLOTS     = 1,
  parameter int LINK_REG       = c_link_reg
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      Valid_i,
  input  logic [DATA_WIDTH-1:0]     ALUResult_i,
  input  logic                      Zero_i,
  input  logic [DATA_WIDTH-1:0]     WriteData_i,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegister_i,
  input  logic [DATA_WIDTH-1:0]     PCPlus4_i,
  input  logic [DATA_WIDTH-1:0]     BranchTarget_i,
  input  logic                      RegWrite_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic                      MemtoReg_i,
  input  logic                      BranchEQ_i,
  input  logic                      BranchNE_i,
  input  logic                      Jal_i,
  output logic                      Valid_o,
  output logic [DATA_WIDTH-1:0]     ALUResult_o,
  output logic [DATA_WIDTH-1:0]     WriteData_o,
  output logic [REG_ADDR_WIDTH-1:0] WriteRegister_o,
  output logic [DATA_WIDTH-1:0]     ForwardValue_o,
  output logic                      RegWrite_o,
  output logic                      MemRead_o,
  output logic                      MemWrite_o,
  output logic                      MemtoReg_o,
  output logic                      BranchTaken_o,
  output logic [DATA_WIDTH-1:0]     BranchTarget_o,
  output logic                      KillActive_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] c_link = REG_ADDR_WIDTH'(LINK_REG);

  ex_mem_ctrl_t w_ctrl;
  logic         w_load;
  logic         w_eff_valid;
  logic         w_taken;

  assign w_ctrl = '{RegWrite: RegWrite_i, MemRead: MemRead_i, MemWrite: MemWrite_i,
                    MemtoReg: MemtoReg_i, BranchEQ: BranchEQ_i, BranchNE: BranchNE_i,
                    Jal: Jal_i};

  assign w_load      = !Flush && !Stall;
  assign w_eff_valid = Valid_i && !KillActive_o;
  assign w_taken     = w_eff_valid && ((w_ctrl.BranchEQ && Zero_i) ||
                                       (w_ctrl.BranchNE && !Zero_i));

  // Every load slot (bubble or not) consumes one pending kill.
  branch_kill_counter #(
    .KILL_SLOTS (KILL_SLOTS)
  ) u_kill (
    .clk     (clk),
    .reset   (reset),
    .clear   (Flush),
    .load    (w_load && w_taken),
    .advance (w_load && !w_taken),
    .active  (KillActive_o)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Valid_o         <= 1'b0;
      ALUResult_o     <= '0;
      WriteData_o     <= '0;
      WriteRegister_o <= '0;
      ForwardValue_o  <= '0;
      RegWrite_o      <= 1'b0;
      MemRead_o       <= 1'b0;
      MemWrite_o      <= 1'b0;
      MemtoReg_o      <= 1'b0;
      BranchTaken_o   <= 1'b0;
      BranchTarget_o  <= '0;
    end else if (Flush) begin
      Valid_o         <= 1'b0;
      ALUResult_o     <= '0;
      WriteData_o     <= '0;
      WriteRegister_o <= '0;
      ForwardValue_o  <= '0;
      RegWrite_o      <= 1'b0;
      MemRead_o       <= 1'b0;
      MemWrite_o      <= 1'b0;
      MemtoReg_o      <= 1'b0;
      BranchTaken_o   <= 1'b0;
      BranchTarget_o  <= '0;
    end else if (!Stall) begin
      Valid_o         <= w_eff_valid;
      ALUResult_o     <= ALUResult_i;
      WriteData_o     <= WriteData_i;
      WriteRegister_o <= w_ctrl.Jal ? c_link : WriteRegister_i;
      ForwardValue_o  <= w_ctrl.Jal ? PCPlus4_i : ALUResult_i;
      RegWrite_o      <= w_eff_valid && (w_ctrl.RegWrite || w_ctrl.Jal);
      MemRead_o       <= w_eff_valid && w_ctrl.MemRead;
      MemWrite_o      <= w_eff_valid && w_ctrl.MemWrite;
      MemtoReg_o      <= w_eff_valid && w_ctrl.MemtoReg;
      BranchTaken_o   <= w_taken;
      BranchTarget_o  <= BranchTarget_i;
    end
  end

endmodule
`default_nettype wire
